vga_sync_receiver: RTL and testbench
====================================

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_SYNC=96, H_BACK=48, H_TOTAL=800, meaning horizontal sync width, back porch and line length in pixel ticks.
REQ-003 SHALL have parameters V_ACTIVE=480, V_SYNC=2, V_BACK=33, V_TOTAL=525, meaning the same quantities in lines.
REQ-004 SHALL have port Clock, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset, input, 1, meaning asynchronous, active-low reset.
REQ-006 SHALL have port iPixelEnable, input, 1, meaning pixel tick qualifier (25 MHz rate from 50 MHz Clock).
REQ-007 SHALL have ports iHsync and iVsync, input, 1 each, meaning active-low sync from the VGA controller.
REQ-008 SHALL have port iRGB, input, 3, meaning {R,G,B} pixel data.
REQ-009 SHALL have ports oX and oY, output, 10 each, meaning active-area pixel coordinate.
REQ-010 SHALL have ports oRGB (output, 3) and oPixelValid (output, 1), meaning captured pixel and its one-clock qualifier.
REQ-011 SHALL have ports oLocked, oFrameStart, oErrLine and oErrFrame, output, 1 each, meaning lock status, frame pulse and error pulses.

Function
REQ-012 SHALL sample iHsync/iVsync/iRGB only on clocks with iPixelEnable=1; no counter or FSM change on other clocks.
REQ-013 SHALL keep the previous sampled sync values; a falling edge is prev=1, current=0 at a tick.
REQ-014 SHALL set hcnt=0 on an hsync falling edge; otherwise increment hcnt per tick, saturating at 1023.
REQ-015 SHALL flag a line error when an hsync fall occurs with hcnt != H_TOTAL-1 (edge arriving after 799 prior ticks is correct).
REQ-016 SHALL increment vcnt on each hsync fall and set vcnt=0 on a vsync fall; vsync fall wins when both coincide.
REQ-017 SHALL flag a frame error when a vsync fall occurs with vcnt != V_TOTAL-1 (pre-edge value).
REQ-018 SHALL run FSM SEARCH -> HLOCK on the first hsync fall; HLOCK -> LOCKED on a vsync fall with no line error that tick.
REQ-019 SHALL in LOCKED count consecutive line errors: 2 -> SEARCH; a good hsync fall clears the count.
REQ-020 SHALL in LOCKED go to HLOCK on a frame error; oLocked=1 only in LOCKED.
REQ-021 SHALL define the active area as H_SYNC+H_BACK <= hcnt < H_SYNC+H_BACK+H_ACTIVE and V_SYNC+V_BACK <= vcnt < V_SYNC+V_BACK+V_ACTIVE (h 144..783, v 35..514).
REQ-022 SHALL, on a tick in LOCKED inside the active area, drive oX=hcnt-144, oY=vcnt-35, oRGB=iRGB and oPixelValid=1 for exactly the following clock (latency 1 clock).
REQ-023 SHALL hold oX/oY/oRGB when oPixelValid=0.
REQ-024 SHALL pulse oFrameStart one clock on each vsync fall while in, or entering, LOCKED.
REQ-025 SHALL pulse oErrLine/oErrFrame one clock per detected error in any FSM state except SEARCH.

Reset
REQ-026 SHALL on Reset=0 immediately force FSM=SEARCH, hcnt=vcnt=0, prev syncs=1, error count=0, all outputs 0.
REQ-027 SHALL, on reset release mid-frame, require a fresh hsync fall then vsync fall before oLocked=1.

Configuration
REQ-028 SHALL with VGA_RX_CRC_EN defined add oFrameCrc (16) and oCrcValid (1); CRC-16-CCITT, poly 0x1021, init 0xFFFF, 3 bits per valid pixel MSB-first (R,G,B), reseeded at each frame start.
REQ-029 SHALL publish oFrameCrc with a one-clock oCrcValid at each vsync fall in LOCKED covering the completed frame; without the macro these ports and logic do not exist.

Structure
REQ-030 SHALL place default timing constants, the FSM state encoding and the CRC polynomial/seed in shared package vga_rx_pkg.
REQ-031 SHALL implement the CRC in sub-module vga_rx_crc16 (3-bit data, enable, seed-load), instantiated only under VGA_RX_CRC_EN.

Verification
REQ-032 SHALL cover: nominal 800x525 stream, pixel-enable every 2nd clock -> oLocked=1 after first vsync fall; 307200 oPixelValid pulses per frame.
REQ-033 SHALL cover: pixel at h=144, v=35 with iRGB=3'b101 -> oX=0, oY=0, oRGB=3'b101; h=783, v=514 -> oX=639, oY=479.
REQ-034 SHALL cover: one 799-tick line while locked -> single oErrLine, oLocked stays 1; two consecutive -> oLocked=0, FSM=SEARCH.
REQ-035 SHALL cover: vsync fall at vcnt=400 -> oErrFrame pulse, oLocked=0, relock at next correct vsync.
REQ-036 SHALL cover: Reset asserted mid-line without clock edge -> outputs 0 at once; after release, no oPixelValid until hsync then vsync falls.
REQ-037 SHALL cover with VGA_RX_CRC_EN: all-black frame twice -> identical oFrameCrc values, each with a one-clock oCrcValid.

Source files
------------

// File: rtl/vga_rx_pkg.sv
// rtl/vga_rx_pkg.sv - shared constants, FSM encoding and CRC helper for the VGA receiver
// Purpose: default 640x480@60 timing, lock FSM state encoding, CRC-16-CCITT
//          polynomial/seed and a 3-bit-per-step CRC update function.
// Ports:   none (package).
// Optional feature macro used by importers: VGA_RX_CRC_EN.
package vga_rx_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_TOTAL  = 525;

  localparam int              CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_HLOCK  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  // Shifts {R,G,B} into the CRC MSB-first, one bit per iteration.
  function automatic logic [15:0] crc16_step3(input logic [15:0] crc, input logic [2:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 2; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_rx_crc16.sv
// rtl/vga_rx_crc16.sv - CRC-16-CCITT accumulator over 3-bit pixel words
// Purpose: running CRC of captured pixels; seed_load has priority over enable.
// Ports:   clk, rst_n (async active-low), seed_load, enable, data[2:0], crc[15:0].
// Instantiated by vga_sync_receiver only when VGA_RX_CRC_EN is defined.
module vga_rx_crc16
  import vga_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic        enable,
  input  logic [2:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_SEED;
    end else if (seed_load) begin
      crc <= CRC_SEED;
    end else if (enable) begin
      crc <= crc16_step3(crc, data);
    end
  end

endmodule

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sync receiver: line/frame tracking, lock FSM, pixel capture
// Purpose: tracks active-low hsync/vsync on pixel ticks, locks to the timing,
//          reports line/frame errors and emits active-area pixels with coordinates.
// Ports:   Clock, Reset (async active-low), iPixelEnable, iHsync, iVsync, iRGB[2:0];
//          oX[9:0], oY[9:0], oRGB[2:0], oPixelValid, oLocked, oFrameStart,
//          oErrLine, oErrFrame; with VGA_RX_CRC_EN also oFrameCrc[15:0], oCrcValid.
// Optional feature macro: VGA_RX_CRC_EN (per-frame CRC of captured pixels).
module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_TOTAL  = DEF_V_TOTAL
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iPixelEnable,
  input  logic        iHsync,
  input  logic        iVsync,
  input  logic [2:0]  iRGB,
  output logic [9:0]  oX,
  output logic [9:0]  oY,
  output logic [2:0]  oRGB,
  output logic        oPixelValid,
  output logic        oLocked,
  output logic        oFrameStart,
  output logic        oErrLine,
  output logic        oErrFrame
`ifdef VGA_RX_CRC_EN
  ,
  output logic [15:0] oFrameCrc,
  output logic        oCrcValid
`endif
);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);

  rx_state_t  state;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       prev_hsync;
  logic       prev_vsync;
  logic       err_pending;   // one line error already seen while locked

  logic       h_fall;
  logic       v_fall;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       line_err;
  logic       frame_err;
  logic       enter_locked;
  logic       pixel_hit;

  // Position of the current tick: the sync-fall tick itself is coordinate 0,
  // so active-area tests and oX/oY use the post-update counter values.
  always_comb begin
    h_fall       = iPixelEnable & prev_hsync & ~iHsync;
    v_fall       = iPixelEnable & prev_vsync & ~iVsync;
    h_next       = h_fall ? 10'd0 : ((hcnt == CNT_MAX) ? hcnt : hcnt + 10'd1);
    if (v_fall)
      v_next = 10'd0;
    else if (h_fall && (vcnt != CNT_MAX))
      v_next = vcnt + 10'd1;
    else
      v_next = vcnt;
    // Error checks use the pre-edge counts.
    line_err     = h_fall && (hcnt != H_LAST);
    frame_err    = v_fall && (vcnt != V_LAST);
    enter_locked = (state == ST_HLOCK) && v_fall && !line_err;
    pixel_hit    = iPixelEnable && (state == ST_LOCKED) &&
                   (h_next >= H_START) && (h_next < H_END) &&
                   (v_next >= V_START) && (v_next < V_END);
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc;

  // Reseeded on every vsync fall; the published value is taken before reseed.
  vga_rx_crc16 u_crc (
    .clk       (Clock),
    .rst_n     (Reset),
    .seed_load (v_fall),
    .enable    (pixel_hit),
    .data      (iRGB),
    .crc       (crc)
  );
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_SEARCH;
      hcnt        <= '0;
      vcnt        <= '0;
      prev_hsync  <= 1'b1;
      prev_vsync  <= 1'b1;
      err_pending <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oRGB        <= '0;
      oPixelValid <= 1'b0;
      oLocked     <= 1'b0;
      oFrameStart <= 1'b0;
      oErrLine    <= 1'b0;
      oErrFrame   <= 1'b0;
`ifdef VGA_RX_CRC_EN
      oFrameCrc   <= '0;
      oCrcValid   <= 1'b0;
`endif
    end else begin
      oPixelValid <= 1'b0;
      oFrameStart <= 1'b0;
      oErrLine    <= 1'b0;
      oErrFrame   <= 1'b0;
`ifdef VGA_RX_CRC_EN
      oCrcValid   <= 1'b0;
`endif
      if (iPixelEnable) begin
        prev_hsync <= iHsync;
        prev_vsync <= iVsync;
        hcnt       <= h_next;
        vcnt       <= v_next;

        if (state != ST_SEARCH) begin
          oErrLine  <= line_err;
          oErrFrame <= frame_err;
        end
        if (v_fall && ((state == ST_LOCKED) || enter_locked))
          oFrameStart <= 1'b1;
        if (pixel_hit) begin
          oX          <= h_next - H_START;
          oY          <= v_next - V_START;
          oRGB        <= iRGB;
          oPixelValid <= 1'b1;
        end
`ifdef VGA_RX_CRC_EN
        if (v_fall && (state == ST_LOCKED)) begin
          oFrameCrc <= crc;
          oCrcValid <= 1'b1;
        end
`endif

        case (state)
          ST_SEARCH: begin
            if (h_fall)
              state <= ST_HLOCK;
          end
          ST_HLOCK: begin
            if (enter_locked) begin
              state       <= ST_LOCKED;
              oLocked     <= 1'b1;
              err_pending <= 1'b0;
            end
          end
          ST_LOCKED: begin
            // Second consecutive bad line drops all the way back to SEARCH.
            if (line_err && err_pending) begin
              state       <= ST_SEARCH;
              oLocked     <= 1'b0;
              err_pending <= 1'b0;
            end else if (frame_err) begin
              state       <= ST_HLOCK;
              oLocked     <= 1'b0;
              err_pending <= 1'b0;
            end else if (line_err) begin
              err_pending <= 1'b1;
            end else if (h_fall) begin
              err_pending <= 1'b0;
            end
          end
          default: begin
            state   <= ST_SEARCH;
            oLocked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed self-checking bench for vga_sync_receiver (reduced timing)
module tb_vga_sync_receiver;
  import vga_rx_pkg::*;

  localparam int H_ACTIVE = 16;
  localparam int H_SYNC   = 4;
  localparam int H_BACK   = 4;
  localparam int H_TOTAL  = 32;
  localparam int V_ACTIVE = 8;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 3;
  localparam int V_TOTAL  = 16;
  localparam int PIX_PER_FRAME = H_ACTIVE * V_ACTIVE;

  logic       Clock;
  logic       Reset;
  logic       iPixelEnable;
  logic       iHsync;
  logic       iVsync;
  logic [2:0] iRGB;
  logic [9:0] oX;
  logic [9:0] oY;
  logic [2:0] oRGB;
  logic       oPixelValid;
  logic       oLocked;
  logic       oFrameStart;
  logic       oErrLine;
  logic       oErrFrame;
`ifdef VGA_RX_CRC_EN
  logic [15:0] oFrameCrc;
  logic        oCrcValid;
`endif

  vga_sync_receiver #(
    .H_ACTIVE(H_ACTIVE), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_TOTAL(V_TOTAL)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iPixelEnable (iPixelEnable),
    .iHsync       (iHsync),
    .iVsync       (iVsync),
    .iRGB         (iRGB),
    .oX           (oX),
    .oY           (oY),
    .oRGB         (oRGB),
    .oPixelValid  (oPixelValid),
    .oLocked      (oLocked),
    .oFrameStart  (oFrameStart),
    .oErrLine     (oErrLine),
    .oErrFrame    (oErrFrame)
`ifdef VGA_RX_CRC_EN
    ,
    .oFrameCrc    (oFrameCrc),
    .oCrcValid    (oCrcValid)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  // Pulse counters: one increment per clock an output is high.
  int pv_cnt = 0;
  int fs_cnt = 0;
  int el_cnt = 0;
  int ef_cnt = 0;
  always @(negedge Clock) begin
    if (oPixelValid) pv_cnt <= pv_cnt + 1;
    if (oFrameStart) fs_cnt <= fs_cnt + 1;
    if (oErrLine)    el_cnt <= el_cnt + 1;
    if (oErrFrame)   ef_cnt <= ef_cnt + 1;
  end

`ifdef VGA_RX_CRC_EN
  int          crc_cnt = 0;
  logic [15:0] crc_log [0:15];
  always @(negedge Clock) begin
    if (oCrcValid) begin
      crc_log[crc_cnt % 16] <= oFrameCrc;
      crc_cnt <= crc_cnt + 1;
    end
  end

  function automatic logic [15:0] model_crc_black(input int npix);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < npix * 3; i++) begin
      fb = c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
`endif

  logic       s_pv;
  logic [9:0] s_x;
  logic [9:0] s_y;
  logic [2:0] s_rgb;
  logic       corner_chk = 1'b0;
  logic       black_mode = 1'b0;

  // One pixel tick: enable on the first clock, idle on the second.
  task automatic tick(input logic hs, input logic vs, input logic [2:0] rgb);
    iHsync = hs;
    iVsync = vs;
    iRGB = rgb;
    iPixelEnable = 1'b1;
    @(posedge Clock); #1;
    s_pv = oPixelValid;
    s_x = oX;
    s_y = oY;
    s_rgb = oRGB;
    iPixelEnable = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic send_line(input int len, input int l);
    logic [2:0] rgb;
    for (int h = 0; h < len; h++) begin
      rgb = black_mode ? 3'b000 : 3'(h ^ l);
      tick(h >= H_SYNC, l >= V_SYNC, rgb);
      if (corner_chk) begin
        if (h == 8 && l == 5) begin
          checks++; if (s_pv !== 1'b1) begin errors++; $display("FAIL first_px_valid got %0b want 1", s_pv); end
          checks++; if (s_x !== 10'd0) begin errors++; $display("FAIL first_px_x got %0d want 0", s_x); end
          checks++; if (s_y !== 10'd0) begin errors++; $display("FAIL first_px_y got %0d want 0", s_y); end
          checks++; if (s_rgb !== 3'b101) begin errors++; $display("FAIL first_px_rgb got %b want 101", s_rgb); end
        end
        if (h == 23 && l == 12) begin
          checks++; if (s_pv !== 1'b1) begin errors++; $display("FAIL last_px_valid got %0b want 1", s_pv); end
          checks++; if (s_x !== 10'd15) begin errors++; $display("FAIL last_px_x got %0d want 15", s_x); end
          checks++; if (s_y !== 10'd7) begin errors++; $display("FAIL last_px_y got %0d want 7", s_y); end
          checks++; if (s_rgb !== 3'b011) begin errors++; $display("FAIL last_px_rgb got %b want 011", s_rgb); end
        end
        if ((h == 7 && l == 5) || (h == 24 && l == 12) || (h == 8 && l == 4) || (h == 8 && l == 13)) begin
          checks++;
          if (s_pv !== 1'b0) begin errors++; $display("FAIL outside_px h=%0d v=%0d valid got %0b want 0", h, l, s_pv); end
        end
      end
    end
  endtask

  task automatic send_frame(input int nlines, input int short_line);
    for (int l = 0; l < nlines; l++)
      send_line((l == short_line) ? H_TOTAL - 1 : H_TOTAL, l);
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    iPixelEnable = 1'b0;
    iHsync = 1'b1;
    iVsync = 1'b1;
    iRGB = 3'b000;
    repeat (3) @(posedge Clock);
    #1;
    checks++; if (oPixelValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", oPixelValid); end
    checks++; if (oLocked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", oLocked); end
    checks++;
    if ({oX, oY, oRGB, oFrameStart, oErrLine, oErrFrame} !== 26'd0) begin
      errors++; $display("FAIL reset_outputs got x=%0d y=%0d rgb=%b fs=%b el=%b ef=%b want all 0", oX, oY, oRGB, oFrameStart, oErrLine, oErrFrame);
    end
    Reset = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_lock;
    int pv0, fs0;
    send_frame(V_TOTAL, -1);
    checks++; if (oLocked !== 1'b0) begin errors++; $display("FAIL lock_early got %0b want 0", oLocked); end
    checks++; if (el_cnt !== 0) begin errors++; $display("FAIL lock_search_errline got %0d want 0", el_cnt); end
    checks++; if (ef_cnt !== 0) begin errors++; $display("FAIL lock_search_errframe got %0d want 0", ef_cnt); end
    pv0 = pv_cnt;
    fs0 = fs_cnt;
    corner_chk = 1'b1;
    send_frame(V_TOTAL, -1);
    corner_chk = 1'b0;
    checks++; if (oLocked !== 1'b1) begin errors++; $display("FAIL lock_after_vsync got %0b want 1", oLocked); end
    checks++; if (fs_cnt - fs0 !== 1) begin errors++; $display("FAIL lock_framestart got %0d want 1", fs_cnt - fs0); end
    checks++; if (pv_cnt - pv0 !== PIX_PER_FRAME) begin errors++; $display("FAIL lock_pixels got %0d want %0d", pv_cnt - pv0, PIX_PER_FRAME); end
  endtask

  task automatic test_back_to_back;
    int pv0, fs0, ef0;
    pv0 = pv_cnt; fs0 = fs_cnt; ef0 = ef_cnt;
    send_frame(V_TOTAL, -1);
    checks++; if (pv_cnt - pv0 !== PIX_PER_FRAME) begin errors++; $display("FAIL b2b_pixels got %0d want %0d", pv_cnt - pv0, PIX_PER_FRAME); end
    checks++; if (fs_cnt - fs0 !== 1) begin errors++; $display("FAIL b2b_framestart got %0d want 1", fs_cnt - fs0); end
    checks++; if (ef_cnt - ef0 !== 0) begin errors++; $display("FAIL b2b_errframe got %0d want 0", ef_cnt - ef0); end
  endtask

  task automatic test_line_error;
    int el0;
    el0 = el_cnt;
    send_frame(V_TOTAL, 3);
    checks++; if (el_cnt - el0 !== 1) begin errors++; $display("FAIL line_err_single got %0d want 1", el_cnt - el0); end
    checks++; if (oLocked !== 1'b1) begin errors++; $display("FAIL line_err_stay_locked got %0b want 1", oLocked); end
    el0 = el_cnt;
    for (int l = 0; l < V_TOTAL; l++) begin
      send_line((l == 3 || l == 4) ? H_TOTAL - 1 : H_TOTAL, l);
      if (l == 5) begin
        checks++; if (oLocked !== 1'b0) begin errors++; $display("FAIL line_err_double_locked got %0b want 0", oLocked); end
        checks++; if (dut.state !== ST_SEARCH) begin errors++; $display("FAIL line_err_double_state got %0d want %0d", dut.state, ST_SEARCH); end
        checks++; if (el_cnt - el0 !== 2) begin errors++; $display("FAIL line_err_double_count got %0d want 2", el_cnt - el0); end
      end
    end
    send_frame(V_TOTAL, -1);
    checks++; if (oLocked !== 1'b1) begin errors++; $display("FAIL line_err_relock got %0b want 1", oLocked); end
  endtask

  task automatic test_frame_error;
    int ef0, pv0;
    ef0 = ef_cnt;
    send_frame(9, -1);
    pv0 = pv_cnt;
    send_frame(V_TOTAL, -1);
    checks++; if (ef_cnt - ef0 !== 1) begin errors++; $display("FAIL frame_err_pulse got %0d want 1", ef_cnt - ef0); end
    checks++; if (oLocked !== 1'b0) begin errors++; $display("FAIL frame_err_unlock got %0b want 0", oLocked); end
    checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL frame_err_no_pixels got %0d want 0", pv_cnt - pv0); end
    send_frame(V_TOTAL, -1);
    checks++; if (oLocked !== 1'b1) begin errors++; $display("FAIL frame_err_relock got %0b want 1", oLocked); end
    checks++; if (ef_cnt - ef0 !== 1) begin errors++; $display("FAIL frame_err_no_extra got %0d want 1", ef_cnt - ef0); end
  endtask

  task automatic test_reset_midline;
    int pv0;
    send_frame(6, -1);
    for (int h = 0; h < 10; h++) tick(h >= H_SYNC, 1'b1, 3'(h));
    iHsync = 1'b1; iVsync = 1'b1; iRGB = 3'b110; iPixelEnable = 1'b1;
    @(posedge Clock); #1;
    checks++; if (oPixelValid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_valid got %0b want 1", oPixelValid); end
    Reset = 1'b0;
    #1;
    checks++; if (oPixelValid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b want 0", oPixelValid); end
    checks++; if (oLocked !== 1'b0) begin errors++; $display("FAIL rst_mid_locked got %0b want 0", oLocked); end
    checks++; if ({oX, oY, oRGB} !== 23'd0) begin errors++; $display("FAIL rst_mid_data got x=%0d y=%0d rgb=%b want 0", oX, oY, oRGB); end
    iPixelEnable = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    pv0 = pv_cnt;
    for (int h = 11; h < H_TOTAL; h++) tick(1'b1, 1'b1, 3'(h));
    for (int l = 7; l < V_TOTAL; l++) send_line(H_TOTAL, l);
    checks++; if (pv_cnt - pv0 !== 0) begin errors++; $display("FAIL rst_mid_no_pixels got %0d want 0", pv_cnt - pv0); end
    checks++; if (oLocked !== 1'b0) begin errors++; $display("FAIL rst_mid_no_lock got %0b want 0", oLocked); end
    pv0 = pv_cnt;
    send_frame(V_TOTAL, -1);
    checks++; if (oLocked !== 1'b1) begin errors++; $display("FAIL rst_mid_relock got %0b want 1", oLocked); end
    checks++; if (pv_cnt - pv0 !== PIX_PER_FRAME) begin errors++; $display("FAIL rst_mid_pixels got %0d want %0d", pv_cnt - pv0, PIX_PER_FRAME); end
  endtask

`ifdef VGA_RX_CRC_EN
  task automatic test_crc;
    int c0;
    logic [15:0] exp_crc;
    exp_crc = model_crc_black(PIX_PER_FRAME);
    c0 = crc_cnt;
    black_mode = 1'b1;
    send_frame(V_TOTAL, -1);
    send_frame(V_TOTAL, -1);
    send_line(H_TOTAL, 0);
    black_mode = 1'b0;
    checks++; if (crc_cnt - c0 !== 3) begin errors++; $display("FAIL crc_valid_pulses got %0d want 3", crc_cnt - c0); end
    checks++; if (crc_log[(c0 + 1) % 16] !== exp_crc) begin errors++; $display("FAIL crc_black_a got %h want %h", crc_log[(c0 + 1) % 16], exp_crc); end
    checks++; if (crc_log[(c0 + 2) % 16] !== exp_crc) begin errors++; $display("FAIL crc_black_b got %h want %h", crc_log[(c0 + 2) % 16], exp_crc); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_back_to_back();
    test_line_error();
    test_frame_error();
    test_reset_midline();
`ifdef VGA_RX_CRC_EN
    test_crc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
